// File: rtl/avg_stream_pkg.sv
// avg_stream_pkg: shared state type and sizing constants for the average-buffer streamer
package avg_stream_pkg;
  typedef enum logic [1:0] {IDLE, HDR, READ, DRAIN} state_t;
  localparam int FRAME_CNT_W = 16;
  localparam int SKID_DEPTH = 2;
endpackage

// File: rtl/avg_skid_fifo.sv
// avg_skid_fifo: 2-entry FIFO whose head drives the stream outputs directly
module avg_skid_fifo
  import avg_stream_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic [1:0]   occ
);
  logic [W-1:0] mem_q [SKID_DEPTH];
  logic         wp_q, rp_q;
  logic [1:0]   cnt_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_q <= '{default: '0};
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wp_q] <= din;
        wp_q        <= ~wp_q;
      end
      if (pop) rp_q <= ~rp_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end
  assign dout  = mem_q[rp_q];
  assign valid = |cnt_q;
  assign occ   = cnt_q;
endmodule

// File: rtl/avg_bram_streamer.sv
// avg_bram_streamer: reads the finished average buffer over BRAM port B and streams it as one AXI4-Stream packet.
// Define AVG_HEADER_EN to prefix each packet with a header word carrying the latched n_avg.
module avg_bram_streamer
  import avg_stream_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   ready,
  input  logic [31-WIDTH:0]      n_avg,
  output logic [WIDTH+1:0]       bram_addr,
  output logic                   bram_en,
  input  logic [DATA_WIDTH-1:0]  bram_rddata,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   overrun,
  input  logic                   overrun_clr
);
  if (WIDTH < 2) begin : g_width_chk
    $error("avg_bram_streamer: WIDTH must be >= 2");
  end
`ifdef AVG_HEADER_EN
  localparam state_t START = HDR;
`else
  localparam state_t START = READ;
`endif
  state_t                 state_q;
  logic [WIDTH-1:0]       idx_q;
  logic [31-WIDTH:0]      n_avg_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;
  logic                   ready_q, arm_q, busy_q, overrun_q, infl_q, infl_last_q;
  logic                   rise, trig, done, pop, issue, push, hdr_push;
  logic [1:0]             occ;
  logic [2:0]             lvl;
  logic [DATA_WIDTH:0]    push_data, head;
  // arm_q masks the first post-reset cycle so an already-high ready is not seen as an edge
  assign rise = ready & ~ready_q & arm_q;
  assign pop  = m_axis_tvalid & m_axis_tready;
  assign done = pop & m_axis_tlast;
  assign trig = rise & (~busy_q | done);
  // counting the beat leaving this cycle keeps 1 word/cycle without overfilling the FIFO
  assign lvl   = {1'b0, occ} + {2'b0, infl_q} - {2'b0, pop};
  assign issue = (state_q == READ) && (lvl < 3'(SKID_DEPTH));
`ifdef AVG_HEADER_EN
  assign hdr_push = (state_q == HDR);
`else
  assign hdr_push = 1'b0;
`endif
  assign push      = infl_q | hdr_push;
  assign push_data = infl_q ? {infl_last_q, bram_rddata} : {1'b0, DATA_WIDTH'(n_avg_q)};
  avg_skid_fifo #(.W(DATA_WIDTH + 1)) u_fifo (
    .clk   (clk),
    .resetn(resetn),
    .push  (push),
    .din   (push_data),
    .pop   (pop),
    .dout  (head),
    .valid (m_axis_tvalid),
    .occ   (occ)
  );
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      n_avg_q     <= '0;
      frame_cnt_q <= '0;
      ready_q     <= 1'b0;
      arm_q       <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      ready_q     <= ready;
      arm_q       <= 1'b1;
      infl_q      <= issue;
      infl_last_q <= issue & (&idx_q);
      if (issue) idx_q <= idx_q + 1'b1;
      if (done) frame_cnt_q <= frame_cnt_q + 1'b1;
      overrun_q <= (rise & busy_q & ~done) ? 1'b1 : overrun_clr ? 1'b0 : overrun_q;
      if (trig) begin
        state_q <= START;
        n_avg_q <= n_avg;
        busy_q  <= 1'b1;
        idx_q   <= '0;
      end else begin
        if (done) busy_q <= 1'b0;
        state_q <= (state_q == HDR) ? READ :
                   (state_q == READ && issue && (&idx_q)) ? DRAIN :
                   (state_q == DRAIN && done) ? IDLE : state_q;
      end
    end
  end
  assign bram_en      = issue;
  assign bram_addr    = {idx_q, 2'b00};
  assign m_axis_tdata = head[DATA_WIDTH-1:0];
  assign m_axis_tlast = head[DATA_WIDTH];
  assign busy         = busy_q;
  assign frame_cnt    = frame_cnt_q;
  assign overrun      = overrun_q;
endmodule
